// File: rtl/fetch_l1i_if.sv
// Fetch-stage bundle: redirect/stall in, instruction out, L2 refill port; master = fetch stage.
// hit_cnt/miss_cnt exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_l1i_if #(
  parameter int LINE_WORDS = 8
) ();
  logic                      mispredict;
  logic [31:0]               override_addr;
  logic                      mstall;
  logic [31:0]               instruction;
  logic                      instr_valid;
  logic [31:0]               PC_f;
  logic [31:0]               PC_fp4;
  logic [32*LINE_WORDS-1:0]  L2_block_read;
  logic [31:0]               L2_addr_read;
  logic                      L2_stall;
  logic                      L2_read_en;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]               hit_cnt;
  logic [31:0]               miss_cnt;
`endif

  modport master (
    input  mispredict, override_addr, mstall, L2_block_read, L2_stall,
    output instruction, instr_valid, PC_f, PC_fp4, L2_addr_read, L2_read_en
`ifdef FETCH_PERF_CNT_EN
    , output hit_cnt, miss_cnt
`endif
  );

  modport slave (
    output mispredict, override_addr, mstall, L2_block_read, L2_stall,
    input  instruction, instr_valid, PC_f, PC_fp4, L2_addr_read, L2_read_en
`ifdef FETCH_PERF_CNT_EN
    , input hit_cnt, miss_cnt
`endif
  );
endinterface

// File: rtl/fetch_l1i.sv
// Fetch stage with direct-mapped L1I: hit -> registered instruction next edge; miss -> L2 refill FSM.
// mstall holds pc/outputs (refill still completes); mispredict wins over mstall. FETCH_PERF_CNT_EN adds counters.
module fetch_l1i #(
  parameter int          LINE_WORDS = 8,
  parameter int          SETS       = 16,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP        = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_l1i_if.master bus
);
  localparam int OB = $clog2(LINE_WORDS) + 2;
  localparam int IB = $clog2(SETS);
  localparam int TW = 32 - OB - IB;
  localparam logic [31:0] LINE_MASK = ~32'((1 << OB) - 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_pc, r_pcf, r_instr, r_miss_addr;
  logic            r_ivld;
  logic [SETS-1:0] r_valid;
  logic [TW-1:0]   r_tag  [SETS];
  logic [31:0]     r_data [SETS][LINE_WORDS];

  logic [IB-1:0]   w_idx, w_fill_idx;
  logic [TW-1:0]   w_tag;
  logic [OB-3:0]   w_off;
  logic [31:0]     w_line_addr;
  logic            w_hit, w_fill, w_miss_start;

  assign w_idx       = r_pc[OB+IB-1:OB];
  assign w_tag       = r_pc[31:OB+IB];
  assign w_off       = r_pc[OB-1:2];
  assign w_line_addr = r_pc & LINE_MASK;
  assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_fill      = (r_state == REQ) && !bus.L2_stall;
  assign w_fill_idx  = r_miss_addr[OB+IB-1:OB];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // A redirect in IDLE suppresses the miss on the stale pc; in REQ the refill always runs to completion.
  always_comb begin
    w_state_nxt  = r_state;
    w_miss_start = 1'b0;
    case (r_state)
      IDLE: if (!w_hit && !bus.mispredict) begin
        w_state_nxt  = REQ;
        w_miss_start = 1'b1;
      end
      REQ:  if (!bus.L2_stall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc        <= RESET_PC;
      r_pcf       <= RESET_PC;
      r_instr     <= NOP;
      r_ivld      <= 1'b0;
      r_valid     <= '0;
      r_miss_addr <= RESET_PC & LINE_MASK;
    end else begin
      if (w_fill)       r_valid[w_fill_idx] <= 1'b1;
      if (w_miss_start) r_miss_addr <= w_line_addr;
      if (bus.mispredict) begin
        r_pc    <= bus.override_addr & ~32'd3;
        r_instr <= NOP;
        r_ivld  <= 1'b0;
      end else if (!bus.mstall) begin
        r_pcf <= r_pc;
        if (r_state == IDLE && w_hit) begin
          r_instr <= r_data[w_idx][w_off];
          r_ivld  <= 1'b1;
          r_pc    <= r_pc + 32'd4;
        end else begin
          r_instr <= NOP;
          r_ivld  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_tag[w_fill_idx] <= r_miss_addr[31:OB+IB];
      for (int k = 0; k < LINE_WORDS; k++)
        r_data[w_fill_idx][k] <= bus.L2_block_read[32*k +: 32];
    end
  end

  assign bus.instruction  = r_instr;
  assign bus.instr_valid  = r_ivld;
  assign bus.PC_f         = r_pcf;
  assign bus.PC_fp4       = r_pcf + 32'd4;
  assign bus.L2_read_en   = (r_state == REQ);
  // Miss address is latched so a redirect during REQ cannot disturb the outstanding request.
  assign bus.L2_addr_read = (r_state == REQ) ? r_miss_addr : w_line_addr;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_hit_cnt, r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == IDLE && w_hit && !bus.mstall && !bus.mispredict && r_hit_cnt != 32'hFFFF_FFFF)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (w_miss_start && r_miss_cnt != 32'hFFFF_FFFF)
        r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`endif
endmodule

// File: tb/tb_fetch_l1i.sv
// Directed bench for fetch_l1i (LINE_WORDS=8, SETS=16, RESET_PC=0); inputs driven and outputs sampled on negedges.
module tb_fetch_l1i;
  localparam int LW = 8;
  localparam logic [31:0] NOPV = 32'h0000_0033;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fetch_l1i_if #(.LINE_WORDS(LW)) bus ();

  fetch_l1i #(.LINE_WORDS(LW), .SETS(16), .RESET_PC(32'h0), .NOP(NOPV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(negedge clk);
  endtask

  task automatic test_reset;
    bus.mispredict = 1'b0; bus.override_addr = '0; bus.mstall = 1'b0;
    bus.L2_stall = 1'b1;   bus.L2_block_read = '0;
    rst_n = 1'b0;
    #12;
    checks++; if (bus.instruction !== NOPV) begin errors++; $display("FAIL rst_instr got %h want %h", bus.instruction, NOPV); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_ivld got %b want 0", bus.instr_valid); end
    checks++; if (bus.PC_f !== 32'h0) begin errors++; $display("FAIL rst_pcf got %h want 0", bus.PC_f); end
    checks++; if (bus.PC_fp4 !== 32'h4) begin errors++; $display("FAIL rst_pcfp4 got %h want 4", bus.PC_fp4); end
    checks++; if (bus.L2_read_en !== 1'b0) begin errors++; $display("FAIL rst_l2en got %b want 0", bus.L2_read_en); end
    checks++; if (bus.L2_addr_read !== 32'h0) begin errors++; $display("FAIL rst_l2addr got %h want 0", bus.L2_addr_read); end
    step(); rst_n = 1'b1;
    repeat (4) step();
    checks++; if (bus.L2_read_en !== 1'b1) begin errors++; $display("FAIL miss_l2en got %b want 1", bus.L2_read_en); end
    checks++; if (bus.L2_addr_read !== 32'h0) begin errors++; $display("FAIL miss_l2addr got %h want 0", bus.L2_addr_read); end
    checks++; if (bus.instruction !== NOPV || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL miss_out got %h/%b want %h/0", bus.instruction, bus.instr_valid, NOPV); end
    checks++; if (bus.PC_f !== 32'h0) begin errors++; $display("FAIL miss_pcf got %h want 0", bus.PC_f); end
  endtask

  task automatic test_fill;
    bus.L2_block_read = {32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7};
    bus.L2_stall = 1'b0;
    step();
    bus.L2_stall = 1'b1;
    checks++; if (bus.L2_read_en !== 1'b0) begin errors++; $display("FAIL fill_l2en got %b want 0", bus.L2_read_en); end
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL fill_early_ivld got %b want 0", bus.instr_valid); end
    step();
    checks++; if (bus.instruction !== 32'h7 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL fill_w0 got %h/%b want 7/1", bus.instruction, bus.instr_valid); end
    checks++; if (bus.PC_f !== 32'h0 || bus.PC_fp4 !== 32'h4) begin errors++; $display("FAIL fill_w0_pc got %h/%h want 0/4", bus.PC_f, bus.PC_fp4); end
    step();
    checks++; if (bus.instruction !== 32'h6 || bus.PC_f !== 32'h4) begin errors++; $display("FAIL fill_w1 got %h@%h want 6@4", bus.instruction, bus.PC_f); end
    step();
    checks++; if (bus.instruction !== 32'h5 || bus.PC_f !== 32'h8) begin errors++; $display("FAIL fill_w2 got %h@%h want 5@8", bus.instruction, bus.PC_f); end
  endtask

  task automatic test_mstall;
    bus.mstall = 1'b1;
    step();
    checks++; if (bus.instruction !== 32'h5 || bus.PC_f !== 32'h8) begin errors++; $display("FAIL stall1 got %h@%h want 5@8", bus.instruction, bus.PC_f); end
    step();
    checks++; if (bus.instruction !== 32'h5 || bus.PC_f !== 32'h8 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL stall2 got %h@%h/%b want 5@8/1", bus.instruction, bus.PC_f, bus.instr_valid); end
    bus.mstall = 1'b0;
    step();
    checks++; if (bus.instruction !== 32'h4 || bus.PC_f !== 32'hC) begin errors++; $display("FAIL resume1 got %h@%h want 4@c", bus.instruction, bus.PC_f); end
    step();
    checks++; if (bus.instruction !== 32'h3 || bus.PC_f !== 32'h10) begin errors++; $display("FAIL resume2 got %h@%h want 3@10", bus.instruction, bus.PC_f); end
  endtask

  task automatic test_line_cross;
    repeat (3) step();
    checks++; if (bus.instruction !== 32'h0 || bus.PC_f !== 32'h1C) begin errors++; $display("FAIL last_word got %h@%h want 0@1c", bus.instruction, bus.PC_f); end
    step();
    checks++; if (bus.L2_read_en !== 1'b1 || bus.L2_addr_read !== 32'h20) begin errors++; $display("FAIL cross_req got %b@%h want 1@20", bus.L2_read_en, bus.L2_addr_read); end
    checks++; if (bus.instr_valid !== 1'b0 || bus.PC_f !== 32'h20) begin errors++; $display("FAIL cross_out got %b@%h want 0@20", bus.instr_valid, bus.PC_f); end
  endtask

  task automatic test_mispredict;
    // Redirect lands on the same edge that completes the line-0x20 refill.
    bus.mispredict = 1'b1; bus.override_addr = 32'd967;
    for (int k = 0; k < LW; k++) bus.L2_block_read[32*k +: 32] = 32'hA0 + k;
    bus.L2_stall = 1'b0;
    step();
    bus.mispredict = 1'b0; bus.L2_stall = 1'b1;
    checks++; if (bus.instruction !== NOPV || bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mp_nop got %h/%b want %h/0", bus.instruction, bus.instr_valid, NOPV); end
    checks++; if (bus.L2_read_en !== 1'b0 || bus.L2_addr_read !== 32'd960) begin errors++; $display("FAIL mp_idle_addr got %b@%h want 0@3c0", bus.L2_read_en, bus.L2_addr_read); end
    step();
    checks++; if (bus.L2_read_en !== 1'b1 || bus.L2_addr_read !== 32'd960) begin errors++; $display("FAIL mp_req got %b@%h want 1@3c0", bus.L2_read_en, bus.L2_addr_read); end
    bus.L2_block_read = {32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666,
                         32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222};
    bus.L2_stall = 1'b0;
    step();
    bus.L2_stall = 1'b1;
    step();
    checks++; if (bus.instruction !== 32'h33333333 || bus.instr_valid !== 1'b1) begin errors++; $display("FAIL mp_instr got %h/%b want 33333333/1", bus.instruction, bus.instr_valid); end
    checks++; if (bus.PC_f !== 32'd964 || bus.PC_fp4 !== 32'd968) begin errors++; $display("FAIL mp_pc got %h/%h want 3c4/3c8", bus.PC_f, bus.PC_fp4); end
    // Mispredict overrides mstall; the concurrently filled line 0x20 must be present.
    bus.mstall = 1'b1; bus.mispredict = 1'b1; bus.override_addr = 32'd40;
    step();
    bus.mstall = 1'b0; bus.mispredict = 1'b0;
    checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL mp_over_stall got ivld %b want 0", bus.instr_valid); end
    step();
    checks++; if (bus.instruction !== 32'hA2 || bus.PC_f !== 32'd40) begin errors++; $display("FAIL mp_fill_kept got %h@%h want a2@28", bus.instruction, bus.PC_f); end
  endtask

  task automatic test_wrap;
    bus.mispredict = 1'b1; bus.override_addr = 32'hFFFF_FFFC;
    step();
    bus.mispredict = 1'b0;
    step();
    checks++; if (bus.L2_read_en !== 1'b1 || bus.L2_addr_read !== 32'hFFFF_FFE0) begin errors++; $display("FAIL wrap_req got %b@%h want 1@ffffffe0", bus.L2_read_en, bus.L2_addr_read); end
    bus.L2_block_read = '0;
    bus.L2_block_read[32*7 +: 32] = 32'hDEAD_BEEF;
    bus.L2_stall = 1'b0;
    step();
    bus.L2_stall = 1'b1;
    step();
    checks++; if (bus.instruction !== 32'hDEAD_BEEF || bus.PC_f !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_last got %h@%h want deadbeef@fffffffc", bus.instruction, bus.PC_f); end
    checks++; if (bus.PC_fp4 !== 32'h0) begin errors++; $display("FAIL wrap_fp4 got %h want 0", bus.PC_fp4); end
    step();
    checks++; if (bus.instruction !== 32'h7 || bus.PC_f !== 32'h0 || bus.PC_fp4 !== 32'h4) begin errors++; $display("FAIL wrap_zero got %h@%h/%h want 7@0/4", bus.instruction, bus.PC_f, bus.PC_fp4); end
  endtask

  task automatic test_reset_mid_req;
    bus.mispredict = 1'b1; bus.override_addr = 32'h100;
    step();
    bus.mispredict = 1'b0;
    step();
    checks++; if (bus.L2_read_en !== 1'b1) begin errors++; $display("FAIL rr_req got %b want 1", bus.L2_read_en); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.L2_read_en !== 1'b0) begin errors++; $display("FAIL rr_async_drop got %b want 0", bus.L2_read_en); end
    bus.L2_block_read = {LW{32'h1234_5678}};
    bus.L2_stall = 1'b0;
    step();
    bus.L2_stall = 1'b1;
    rst_n = 1'b1;
    step();
    checks++; if (bus.L2_read_en !== 1'b1 || bus.L2_addr_read !== 32'h0) begin errors++; $display("FAIL rr_refetch got %b@%h want 1@0", bus.L2_read_en, bus.L2_addr_read); end
    bus.L2_block_read = '0;
    bus.L2_block_read[31:0] = 32'hFFFF_FFFF;
    bus.L2_stall = 1'b0;
    step();
    bus.L2_stall = 1'b1;
    step();
    checks++; if (bus.instruction !== 32'hFFFF_FFFF || bus.instr_valid !== 1'b1 || bus.PC_f !== 32'h0) begin errors++; $display("FAIL rr_data got %h/%b@%h want ffffffff/1@0", bus.instruction, bus.instr_valid, bus.PC_f); end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf;
    repeat (7) step();
    checks++; if (bus.hit_cnt !== 32'd8) begin errors++; $display("FAIL perf_hit got %0d want 8", bus.hit_cnt); end
    checks++; if (bus.miss_cnt !== 32'd1) begin errors++; $display("FAIL perf_miss got %0d want 1", bus.miss_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_mstall();
    test_line_cross();
    test_mispredict();
    test_wrap();
    test_reset_mid_req();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
